// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB4 requester: valid/ready request port to APB SETUP/ACCESS transfers
// Optional feature macro: APB_MASTER_TIMEOUT_EN (PREADY wait-state timeout)

`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef APB_STRB_WIDTH
`define APB_STRB_WIDTH 4
`endif
`ifndef APB_PROT_WIDTH
`define APB_PROT_WIDTH 3
`endif

module apb_master #(
  parameter int ADDR_WIDTH     = `APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `APB_DATA_WIDTH,
  parameter int STRB_WIDTH     = `APB_STRB_WIDTH,
  parameter int PROT_WIDTH     = `APB_PROT_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // request port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_strb,
  input  logic [PROT_WIDTH-1:0] req_prot,
  // response strobe
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB requester side
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  output logic [PROT_WIDTH-1:0] PPROT,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [STRB_WIDTH-1:0]   pstrb_q;
  logic [PROT_WIDTH-1:0]   pprot_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic                    rsp_timeout_q;

  logic                    xfer_done;
  logic                    timeout_hit;
  logic                    accept;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tcnt_q;

  // Abort on the last allowed wait cycle; a PREADY=1 in that cycle still completes normally.
  assign timeout_hit = (state_q == ST_ACCESS) && !PREADY &&
                       (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the timeout the ACCESS phase waits indefinitely; the parameter is kept so both
  // builds share one interface.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES < 1);
`endif

  // Completion and request acceptance; ready is suppressed while reset is asserted.
  assign xfer_done = (state_q == ST_ACCESS) && PREADY;
  assign req_ready = !PRESET && ((state_q == ST_IDLE) || xfer_done);
  assign accept    = req_valid && req_ready;

  // Transfer FSM with registered APB outputs and response registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      tcnt_q        <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;

      case (state_q)
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          tcnt_q    <= '0;
`endif
        end

        ST_ACCESS: begin
          if (PREADY) begin
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= PSLVERR;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
            // Default to IDLE; a same-cycle accept below overrides this with a new SETUP.
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pstrb_q       <= '0;
            state_q       <= ST_IDLE;
          end else if (timeout_hit) begin
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pstrb_q       <= '0;
            state_q       <= ST_IDLE;
          end else begin
`ifdef APB_MASTER_TIMEOUT_EN
            tcnt_q <= tcnt_q + CNT_W'(1);
`endif
          end
        end

        default: begin
        end
      endcase

      // Accept from IDLE or on completion; reads never drive byte strobes.
      if (accept) begin
        pwrite_q  <= req_write;
        paddr_q   <= req_addr;
        pwdata_q  <= req_wdata;
        pstrb_q   <= req_write ? req_strb : '0;
        pprot_q   <= req_prot;
        psel_q    <= 1'b1;
        penable_q <= 1'b0;
        state_q   <= ST_SETUP;
      end
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed table-driven bench for apb_master
`timescale 1ns/1ps

module tb_apb_master;

  logic        pclk;
  logic        preset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  apb_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .PROT_WIDTH(3), .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK(pclk), .PRESET(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to 1ns after the next rising edge; callers drive inputs, then #1 before sampling.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    req_valid = v; req_write = wr; req_addr = a; req_wdata = d; req_strb = s; req_prot = p;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    // cycle N: request accepted from IDLE
    tick();
    drive_req(1'b1, v.wr, v.addr, v.wdata, v.strb, v.prot);
    pready = 1'b0; pslverr = 1'b0; prdata = 32'hBAD0BAD0;
    #1;
    chk({tag, " idle ready"}, req_ready, 1);
    // cycle N+1: SETUP
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
    #1;
    chk({tag, " setup psel"}, psel, 1);
    chk({tag, " setup penable"}, penable, 0);
    chk({tag, " setup pwrite"}, pwrite, v.wr);
    chk({tag, " setup paddr"}, paddr, v.addr);
    chk({tag, " setup pstrb"}, pstrb, v.exp_pstrb);
    chk({tag, " setup pprot"}, pprot, v.prot);
    chk({tag, " setup ready"}, req_ready, 0);
    if (v.wr) chk({tag, " setup pwdata"}, pwdata, v.wdata);
    // ACCESS cycles: v.waits wait states then completion
    for (int w = 0; w <= v.waits; w++) begin
      tick();
      pready  = (w == v.waits);
      pslverr = (w == v.waits) ? v.slverr : 1'b0;
      prdata  = (w == v.waits) ? v.prdata : 32'hBAD0BAD0;
      #1;
      chk({tag, " access psel"}, psel, 1);
      chk({tag, " access penable"}, penable, 1);
      chk({tag, " access paddr"}, paddr, v.addr);
      chk({tag, " access pstrb"}, pstrb, v.exp_pstrb);
      chk({tag, " access ready"}, req_ready, (w == v.waits));
      chk({tag, " access rsp_valid"}, rsp_valid, 0);
      if (v.wr) chk({tag, " access pwdata"}, pwdata, v.wdata);
    end
    // response cycle
    tick();
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    #1;
    chk({tag, " rsp_valid"}, rsp_valid, 1);
    chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, " rsp_err"}, rsp_err, v.exp_err);
    chk({tag, " rsp_timeout"}, rsp_timeout, 0);
    chk({tag, " idle psel"}, psel, 0);
    chk({tag, " idle penable"}, penable, 0);
    chk({tag, " idle pstrb"}, pstrb, 0);
    chk({tag, " idle paddr hold"}, paddr, v.addr);
    tick();
    #1;
    chk({tag, " rsp pulse end"}, rsp_valid, 0);
  endtask

  initial begin
    //           wr    addr   wdata         strb prot waits err  prdata        pstrb rdata         err
    vecs[0] = '{1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 32'h12345678, 4'hF, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 32'd5, 32'h0,        4'hF, 3'd0, 0, 1'b0, 32'hDEADBEEF, 4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h10, 32'hA5A50001, 4'h3, 3'd2, 3, 1'b1, 32'h55555555, 4'h3, 32'h0,       1'b1};
    vecs[3] = '{1'b0, 32'h20, 32'h0,        4'h0, 3'd5, 1, 1'b1, 32'hCAFEF00D, 4'h0, 32'hCAFEF00D, 1'b1};

    preset = 1'b1;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;

    // reset state
    tick();
    #1;
    chk("reset ready", req_ready, 0);
    chk("reset psel", psel, 0);
    chk("reset penable", penable, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    tick();
    preset = 1'b0;
    #1;
    chk("post-reset ready", req_ready, 1);
    chk("post-reset paddr", paddr, 0);
    chk("post-reset pstrb", pstrb, 0);
    chk("post-reset rsp_rdata", rsp_rdata, 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

`ifdef APB_MASTER_TIMEOUT_EN
    // PREADY stuck low: abort after 4 wait cycles
    tick();
    drive_req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 3'h1);
    prdata = 32'h77777777;
    #1;
    chk("to accept", req_ready, 1);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
    #1;
    chk("to setup psel", psel, 1);
    for (int w = 0; w < 4; w++) begin
      tick();
      #1;
      chk("to wait penable", penable, 1);
      chk("to wait ready", req_ready, 0);
      chk("to wait rsp_valid", rsp_valid, 0);
    end
    tick();
    #1;
    chk("to psel", psel, 0);
    chk("to penable", penable, 0);
    chk("to rsp_valid", rsp_valid, 1);
    chk("to rsp_err", rsp_err, 1);
    chk("to rsp_timeout", rsp_timeout, 1);
    chk("to rsp_rdata", rsp_rdata, 0);
    chk("to idle ready", req_ready, 1);
`endif

    // three back-to-back zero-wait writes, req_valid held
    tick();
    drive_req(1'b1, 1'b1, 32'h101, 32'h1001, 4'hF, 3'd0);
    pready = 1'b0;
    #1;
    chk("b2b accept0", req_ready, 1);
    for (int k = 0; k < 3; k++) begin
      // SETUP of transfer k; present the next request
      tick();
      if (k < 2) drive_req(1'b1, 1'b1, 32'h102 + k, 32'h1002 + k, 4'hF, 3'd0);
      else       drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
      pready = 1'b0;
      #1;
      chk($sformatf("b2b%0d setup psel", k), psel, 1);
      chk($sformatf("b2b%0d setup penable", k), penable, 0);
      chk($sformatf("b2b%0d setup paddr", k), paddr, 32'h101 + k);
      chk($sformatf("b2b%0d setup pwdata", k), pwdata, 32'h1001 + k);
      chk($sformatf("b2b%0d setup ready", k), req_ready, 0);
      chk($sformatf("b2b%0d setup rsp_valid", k), rsp_valid, (k > 0));
      // ACCESS of transfer k, zero wait
      tick();
      pready = 1'b1;
      #1;
      chk($sformatf("b2b%0d access psel", k), psel, 1);
      chk($sformatf("b2b%0d access penable", k), penable, 1);
      chk($sformatf("b2b%0d access ready", k), req_ready, 1);
      chk($sformatf("b2b%0d access rsp_valid", k), rsp_valid, 0);
    end
    tick();
    pready = 1'b0;
    #1;
    chk("b2b last rsp_valid", rsp_valid, 1);
    chk("b2b last rsp_err", rsp_err, 0);
    chk("b2b end psel", psel, 0);
    tick();
    #1;
    chk("b2b end rsp_valid", rsp_valid, 0);

    // reset asserted while ACCESS completes: transfer is dropped
    tick();
    drive_req(1'b1, 1'b1, 32'h33, 32'h3333, 4'h5, 3'd7);
    #1;
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
    #1;
    chk("rst setup psel", psel, 1);
    tick();
    preset = 1'b1; pready = 1'b1; prdata = 32'h99999999;
    #1;
    chk("rst access penable", penable, 1);
    chk("rst cycle ready", req_ready, 0);
    tick();
    preset = 1'b0; pready = 1'b0;
    #1;
    chk("rst psel", psel, 0);
    chk("rst penable", penable, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst paddr", paddr, 0);
    chk("rst pwdata", pwdata, 0);
    chk("rst pstrb", pstrb, 0);
    chk("rst pprot", pprot, 0);
    chk("rst pwrite", pwrite, 0);
    chk("rst ready", req_ready, 1);
    tick();
    #1;
    chk("rst no late rsp", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
